cache_fill_ctrl: RTL
====================

Name: cache_fill_ctrl

Overview:
- Read-request front end for the dual-port tagged cache. It sits directly upstream of `cache_DP`.
- Accepts one read request at a time. It looks up the address on cache port B (zero read latency).
- On a hit it returns the cached data. On a miss it fetches from backing memory, fills the cache through port A, then returns the fetched data.
- It keeps saturating hit/miss counters for performance debug.

Parameters:
- IDX_BITS, 2, cache index width; must equal the cache instance's IDX_BITS.
- DATA_WIDTH, 16, data word width.
- ADDR_WIDTH, 8, full request address width; tag = ADDR_WIDTH-IDX_BITS.
- CNT_WIDTH, 8, hit/miss counter width.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; high only in IDLE.
- req_addr_i  in  ADDR_WIDTH  request address.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  DATA_WIDTH  response data.
- rsp_hit_o  out  1  response was served from the cache.
- mem_req_valid_o  out  1  backing-memory request valid.
- mem_req_ready_i  in  1  backing-memory request ready.
- mem_req_addr_o  out  ADDR_WIDTH  backing-memory address.
- mem_rsp_valid_i  in  1  backing-memory data valid; single-cycle pulse, no backpressure.
- mem_rsp_data_i  in  DATA_WIDTH  backing-memory data.
- cache_addra_o  out  ADDR_WIDTH  cache port A address (fill).
- cache_wdata_o  out  DATA_WIDTH  cache fill data.
- cache_cea_o  out  1  cache port A enable.
- cache_we_o  out  1  cache write enable.
- cache_addrb_o  out  ADDR_WIDTH  cache port B address (lookup).
- cache_ceb_o  out  1  cache port B enable.
- cache_rdatab_i  in  DATA_WIDTH  cache port B read data.
- cache_rhitb_i  in  1  cache port B tag hit.
- hit_count_o  out  CNT_WIDTH  saturating hit count.
- miss_count_o  out  CNT_WIDTH  saturating miss count.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, counters are 0, and the address/data registers are 0.
- Reset is asynchronous and may assert mid-operation (any state). It aborts the transaction with no response.
- A mem_rsp_valid_i pulse arriving after reset while in IDLE is ignored.
- The FSM has six states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch req_addr_i into addr_q and go to LOOKUP.
- LOOKUP (1 cycle):
  - Drive cache_addrb_o=addr_q, cache_ceb_o=1.
  - If cache_rhitb_i: latch cache_rdatab_i, set hit_q=1, increment hit_count, go to RESP.
  - Otherwise: increment miss_count, go to MISS_REQ.
- MISS_REQ:
  - Drive mem_req_valid_o=1 and mem_req_addr_o=addr_q, held stable until mem_req_ready_i.
  - On handshake go to MISS_WAIT.
  - A mem_rsp_valid_i pulse in this state is a protocol violation; the bench asserts on it and the RTL ignores it.
- MISS_WAIT:
  - Wait for mem_rsp_valid_i; no timeout.
  - On the pulse, latch mem_rsp_data_i, set hit_q=0, go to FILL.
- FILL (1 cycle):
  - Drive cache_addra_o=addr_q, cache_wdata_o=data_q, cache_cea_o=1, cache_we_o=1. Go to RESP.
  - The written entry's tag is taken from cache_addra_o upper bits.
- RESP:
  - rsp_valid_o=1, with rsp_data_o=data_q and rsp_hit_o=hit_q held stable until rsp_ready_i.
  - On handshake go to IDLE.
  - A new request is accepted no earlier than the following cycle (no bypass).
- Cache enables:
  - cache_ceb_o is high only in LOOKUP.
  - cache_cea_o and cache_we_o are high only in FILL.
  - Port A write and port B read are therefore never concurrent.
  - Address outputs equal addr_q at all times.
- Latency:
  - Hit: request handshake at cycle 0; rsp_valid_o at cycle 2.
  - Miss: rsp_valid_o 2 cycles after the mem_rsp_valid_i pulse (FILL, then RESP).
- Counters: increment by 1 and saturate at all-ones with no wrap. They are cleared only by reset.
- mem_req_ready_i high in the same cycle mem_req_valid_o first rises completes that handshake in one cycle.
- A refill on an index whose stored tag differs overwrites the entry; this is a direct-mapped replacement.

Test Plan:
1. Reset, then request addr 0x13 with an empty cache -> miss.
   - mem_req_addr_o=0x13; memory returns 0xBEEF.
   - One FILL cycle with cache_addra_o=0x13, cache_wdata_o=0xBEEF.
   - Response 0xBEEF with rsp_hit_o=0; miss_count_o=1.
2. Repeat request 0x13 -> hit.
   - rsp_valid_o 2 cycles after accept; data 0xBEEF, rsp_hit_o=1.
   - No mem_req_valid_o; hit_count_o=1.
3. Request 0x17 (same index 3, different tag) -> miss.
   - Fill 0x1234, which replaces the entry.
   - A subsequent 0x13 request misses again.
4. Backpressure: hold mem_req_ready_i=0 for 5 cycles, then hold rsp_ready_i=0 for 4 cycles.
   - mem_req_addr_o and rsp_data_o stay stable.
   - req_ready_o stays 0 throughout; exactly one response is delivered.
5. Assert reset while in MISS_WAIT, then pulse mem_rsp_valid_i.
   - No response, no cache write (cache_we_o stays 0), counters read 0.
   - The next request is accepted normally.
6. Issue 260 hits with CNT_WIDTH=8 -> hit_count_o saturates at 255 and does not wrap.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: single-outstanding read front end; looks up on cache port B,
// refills through port A on a miss, and answers with the cached or fetched word.
module cache_fill_ctrl #(
    parameter int IDX_BITS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_hit_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    output logic [ADDR_WIDTH-1:0] cache_addra_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    output logic                  cache_cea_o,
    output logic                  cache_we_o,
    output logic [ADDR_WIDTH-1:0] cache_addrb_o,
    output logic                  cache_ceb_o,
    input  logic [DATA_WIDTH-1:0] cache_rdatab_i,
    input  logic                  cache_rhitb_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_MISS_REQ  = 3'd2;
    localparam logic [2:0] S_MISS_WAIT = 3'd3;
    localparam logic [2:0] S_FILL      = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    logic [2:0]                     state_q, state_d;
    logic [ADDR_WIDTH-IDX_BITS-1:0] tag_q, tag_d;
    logic [IDX_BITS-1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [DATA_WIDTH-1:0]          data_q, data_d;
    logic                           hit_q, hit_d;
    logic [CNT_WIDTH-1:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    assign addr_q = {tag_q, idx_q};

    always_comb begin
        state_d    = state_q;
        {tag_d, idx_d} = {tag_q, idx_q};
        data_d     = data_q;
        hit_d      = hit_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                {tag_d, idx_d} = req_addr_i;
                state_d = S_LOOKUP;
            end
            S_LOOKUP: if (cache_rhitb_i) begin
                data_d    = cache_rdatab_i;
                hit_d     = 1'b1;
                hit_cnt_d = hit_cnt_q + {{(CNT_WIDTH-1){1'b0}}, ~&hit_cnt_q};
                state_d   = S_RESP;
            end else begin
                miss_cnt_d = miss_cnt_q + {{(CNT_WIDTH-1){1'b0}}, ~&miss_cnt_q};
                state_d    = S_MISS_REQ;
            end
            S_MISS_REQ: state_d = mem_req_ready_i ? S_MISS_WAIT : S_MISS_REQ;
            S_MISS_WAIT: if (mem_rsp_valid_i) begin
                data_d  = mem_rsp_data_i;
                hit_d   = 1'b0;
                state_d = S_FILL;
            end
            S_FILL: state_d = S_RESP;
            S_RESP: state_d = rsp_ready_i ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // ready is masked while reset is held so every output reads 0 during reset
    assign req_ready_o     = (state_q == S_IDLE) && !reset;
    assign rsp_valid_o     = state_q == S_RESP;
    assign rsp_data_o      = data_q;
    assign rsp_hit_o       = hit_q;
    assign mem_req_valid_o = state_q == S_MISS_REQ;
    assign mem_req_addr_o  = addr_q;
    assign cache_addra_o   = addr_q;
    assign cache_wdata_o   = data_q;
    assign cache_cea_o     = state_q == S_FILL;
    assign cache_we_o      = state_q == S_FILL;
    assign cache_addrb_o   = addr_q;
    assign cache_ceb_o     = state_q == S_LOOKUP;
    assign hit_count_o     = hit_cnt_q;
    assign miss_count_o    = miss_cnt_q;
endmodule
